// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg: shared definitions for the instruction-memory boot loader.
//   IMEM_DEPTH  - instruction memory size in 32-bit words (shared with inst_mem)
//   IMEM_CNT_W  - width of the word-count header and internal counters
//   ld_state_t  - loader FSM state encoding
package imem_loader_pkg;

  localparam int unsigned IMEM_DEPTH = 64;
  localparam int unsigned IMEM_CNT_W = 16;

  typedef enum logic [2:0] {
    ST_LEN_LO = 3'd0,
    ST_LEN_HI = 3'd1,
    ST_DATA   = 3'd2,
    ST_WRITE  = 3'd3,
    ST_DONE   = 3'd4,
    ST_ERR    = 3'd5
  } ld_state_t;

endpackage

// File: rtl/imem_loader_byte_packer.sv
// imem_loader_byte_packer: assembles four little-endian bytes into a word.
//   clock, reset   - clock / async active-high reset
//   i_clr          - synchronous clear of lane counter and assembly register
//   i_en           - a byte is accepted this cycle
//   i_byte         - byte to store at the current lane
//   o_word         - assembly register with i_byte already merged at the current lane
//   o_word_ready   - high when the byte accepted this cycle completes a word
module imem_loader_byte_packer (
  input  logic        clock,
  input  logic        reset,
  input  logic        i_clr,
  input  logic        i_en,
  input  logic [7:0]  i_byte,
  output logic [31:0] o_word,
  output logic        o_word_ready
);

  logic [1:0]  r_lane;
  logic [31:0] r_word;
  logic [31:0] w_word;

  // Merged view lets the caller register the complete word on the same edge
  // the 4th byte is accepted.
  always_comb begin
    w_word = r_word;
    case (r_lane)
      2'd0:    w_word[7:0]   = i_byte;
      2'd1:    w_word[15:8]  = i_byte;
      2'd2:    w_word[23:16] = i_byte;
      default: w_word[31:24] = i_byte;
    endcase
  end

  assign o_word       = w_word;
  assign o_word_ready = i_en && (r_lane == 2'd3);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_lane <= '0;
      r_word <= '0;
    end else if (i_clr) begin
      r_lane <= '0;
      r_word <= '0;
    end else if (i_en) begin
      r_lane <= r_lane + 2'd1;
      r_word <= w_word;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// imem_loader: boot-time program loader feeding the instruction-memory write port.
// Stream format: 16-bit little-endian word count, then little-endian 32-bit words.
//   clock, reset  - clock / async active-high reset
//   start         - restart pulse, honoured only in DONE or ERR
//   byte_in/byte_valid/byte_ready - byte stream handshake
//   wr_en/wr_addr/wr_data         - instruction-memory write port (byte address)
//   cpu_hold      - processor reset, released only in DONE
//   done / error  - load complete / header count exceeded DEPTH
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int unsigned DEPTH = IMEM_DEPTH,
  parameter int unsigned CNT_W = IMEM_CNT_W
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  byte_in,
  input  logic        byte_valid,
  output logic        byte_ready,
  output logic        wr_en,
  output logic [31:0] wr_addr,
  output logic [31:0] wr_data,
  output logic        cpu_hold,
  output logic        done,
  output logic        error
);

  ld_state_t r_state, w_state_next;

  logic [CNT_W-1:0] r_count, r_word_idx, w_full_count;
  logic [31:0]      r_wr_addr, r_wr_data, w_word;
  logic             r_byte_ready, r_wr_en, r_cpu_hold, r_done, r_error;
  logic             w_byte_ready_d, w_wr_en_d, w_cpu_hold_d, w_done_d, w_error_d;
  logic             w_xfer, w_start_ok, w_word_ready, w_pack_en, w_pack_clr;

  assign w_xfer       = byte_valid && r_byte_ready;
  assign w_start_ok   = start && ((r_state == ST_DONE) || (r_state == ST_ERR));
  assign w_full_count = CNT_W'({byte_in, r_count[7:0]});
  assign w_pack_en    = w_xfer && (r_state == ST_DATA);
  // Clearing during LEN_HI guarantees every load starts at lane 0.
  assign w_pack_clr   = w_start_ok || (r_state == ST_LEN_HI);

  imem_loader_byte_packer u_packer (
    .clock        (clock),
    .reset        (reset),
    .i_clr        (w_pack_clr),
    .i_en         (w_pack_en),
    .i_byte       (byte_in),
    .o_word       (w_word),
    .o_word_ready (w_word_ready)
  );

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= ST_LEN_LO;
    else       r_state <= w_state_next;
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_LEN_LO: if (w_xfer) w_state_next = ST_LEN_HI;
      ST_LEN_HI: begin
        if (w_xfer) begin
          if (w_full_count == '0)                w_state_next = ST_DONE;
          else if (w_full_count > CNT_W'(DEPTH)) w_state_next = ST_ERR;
          else                                   w_state_next = ST_DATA;
        end
      end
      ST_DATA:   if (w_word_ready) w_state_next = ST_WRITE;
      ST_WRITE:  w_state_next = ((r_word_idx + CNT_W'(1)) == r_count) ? ST_DONE : ST_DATA;
      ST_DONE,
      ST_ERR:    if (start) w_state_next = ST_LEN_LO;
      default:   w_state_next = ST_LEN_LO;
    endcase
  end

  // Output decode from the next state so every output is a register that
  // matches the state it is in.
  always_comb begin
    w_byte_ready_d = (w_state_next == ST_LEN_LO) || (w_state_next == ST_LEN_HI) ||
                     (w_state_next == ST_DATA);
    w_wr_en_d      = (w_state_next == ST_WRITE);
    w_cpu_hold_d   = (w_state_next != ST_DONE);
    w_done_d       = (w_state_next == ST_DONE);
    w_error_d      = (w_state_next == ST_ERR);
  end

  // Datapath and output registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_count      <= '0;
      r_word_idx   <= '0;
      r_wr_addr    <= '0;
      r_wr_data    <= '0;
      r_byte_ready <= 1'b0;
      r_wr_en      <= 1'b0;
      r_cpu_hold   <= 1'b1;
      r_done       <= 1'b0;
      r_error      <= 1'b0;
    end else begin
      r_byte_ready <= w_byte_ready_d;
      r_wr_en      <= w_wr_en_d;
      r_cpu_hold   <= w_cpu_hold_d;
      r_done       <= w_done_d;
      r_error      <= w_error_d;

      if (w_start_ok) begin
        r_count    <= '0;
        r_word_idx <= '0;
        r_wr_addr  <= '0;
      end else begin
        case (r_state)
          ST_LEN_LO: if (w_xfer) r_count <= {r_count[CNT_W-1:8], byte_in};
          ST_LEN_HI: if (w_xfer) begin
            r_count    <= w_full_count;
            r_word_idx <= '0;
          end
          ST_DATA:   if (w_word_ready) begin
            r_wr_data <= w_word;
            r_wr_addr <= 32'({r_word_idx, 2'b00});
          end
          ST_WRITE:  r_word_idx <= r_word_idx + CNT_W'(1);
          default:   ;
        endcase
      end
    end
  end

  assign byte_ready = r_byte_ready;
  assign wr_en      = r_wr_en;
  assign wr_addr    = r_wr_addr;
  assign wr_data    = r_wr_data;
  assign cpu_hold   = r_cpu_hold;
  assign done       = r_done;
  assign error      = r_error;

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed self-checking bench for imem_loader.
module tb_imem_loader;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  byte_in = '0;
  logic        byte_valid = 1'b0;
  logic        byte_ready, wr_en, cpu_hold, done, error;
  logic [31:0] wr_addr, wr_data;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  int unsigned n_wr = 0;
  logic [31:0] last_wr_addr = '0;
  logic [31:0] last_wr_data = '0;

  imem_loader #(.DEPTH(64), .CNT_W(16)) dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .byte_in    (byte_in),
    .byte_valid (byte_valid),
    .byte_ready (byte_ready),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .cpu_hold   (cpu_hold),
    .done       (done),
    .error      (error)
  );

  always #5 clock = ~clock;

  // Write-port monitor, sampled on the inactive edge.
  always @(negedge clock) begin
    if (wr_en) begin
      n_wr         = n_wr + 1;
      last_wr_addr = wr_addr;
      last_wr_data = wr_data;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int unsigned n;
    n = 0;
    byte_in    = b;
    byte_valid = 1'b1;
    while (!byte_ready && n < 20) begin
      tick();
      n++;
    end
    if (!byte_ready) check("ready_timeout", 32'(byte_ready), 32'd1);
    else tick();
    byte_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_rdy"},  32'(byte_ready), 32'd0);
    check({tag, "_wren"}, 32'(wr_en),      32'd0);
    check({tag, "_addr"}, wr_addr,         32'h0);
    check({tag, "_data"}, wr_data,         32'h0);
    check({tag, "_hold"}, 32'(cpu_hold),   32'd1);
    check({tag, "_done"}, 32'(done),       32'd0);
    check({tag, "_err"},  32'(error),      32'd0);
  endtask

  initial begin
    int unsigned wr0;
    logic [7:0] tv [6];
    int unsigned idx;
    int unsigned cyc;

    // ---- reset state and first-ready latency
    tick();
    check_reset_vals("rst");
    reset = 1'b0;
    #1;
    check("rst_rel_rdy", 32'(byte_ready), 32'd0);
    tick();
    check("rdy_after_rst", 32'(byte_ready), 32'd1);

    // ---- two-word load
    wr0 = n_wr;
    send_byte(8'h02); send_byte(8'h00);
    send_byte(8'h13); send_byte(8'h05); send_byte(8'h50); send_byte(8'h00);
    check("w0_en",   32'(wr_en),      32'd1);
    check("w0_addr", wr_addr,         32'h0);
    check("w0_data", wr_data,         32'h00500513);
    check("w0_rdy",  32'(byte_ready), 32'd0);
    tick();
    check("w0_pulse", 32'(wr_en),      32'd0);
    check("w0_hold_data", wr_data,     32'h00500513);
    check("w0_rdy2", 32'(byte_ready), 32'd1);
    send_byte(8'h93); send_byte(8'h05); send_byte(8'h70); send_byte(8'h00);
    check("w1_en",   32'(wr_en),    32'd1);
    check("w1_addr", wr_addr,       32'h4);
    check("w1_data", wr_data,       32'h00700593);
    check("w1_hold", 32'(cpu_hold), 32'd1);
    tick();
    check("ld2_done", 32'(done),     32'd1);
    check("ld2_hold", 32'(cpu_hold), 32'd0);
    check("ld2_wren", 32'(wr_en),    32'd0);
    check("ld2_nwr",  n_wr - wr0,    32'd2);

    // ---- zero-length header
    do_reset();
    wr0 = n_wr;
    send_byte(8'h00);
    check("z_not_done", 32'(done), 32'd0);
    send_byte(8'h00);
    check("z_done", 32'(done),       32'd1);
    check("z_hold", 32'(cpu_hold),   32'd0);
    check("z_rdy",  32'(byte_ready), 32'd0);
    tick();
    check("z_nwr",  n_wr - wr0,      32'd0);

    // ---- start from DONE, then oversize header -> ERR
    pulse_start();
    check("st_done", 32'(done),       32'd0);
    check("st_hold", 32'(cpu_hold),   32'd1);
    check("st_rdy",  32'(byte_ready), 32'd1);
    send_byte(8'h41); send_byte(8'h00);
    check("e_err",  32'(error),      32'd1);
    check("e_hold", 32'(cpu_hold),   32'd1);
    check("e_rdy",  32'(byte_ready), 32'd0);
    byte_in = 8'h55; byte_valid = 1'b1;
    tick(); tick(); tick();
    check("e_stuck_err", 32'(error),      32'd1);
    check("e_stuck_rdy", 32'(byte_ready), 32'd0);
    byte_valid = 1'b0;
    pulse_start();
    check("e_clr_err", 32'(error),      32'd0);
    check("e_clr_rdy", 32'(byte_ready), 32'd1);

    // ---- one word with byte_valid toggling every cycle
    wr0 = n_wr;
    tv[0] = 8'h01; tv[1] = 8'h00; tv[2] = 8'hEF; tv[3] = 8'hBE; tv[4] = 8'hAD; tv[5] = 8'hDE;
    idx = 0; cyc = 0;
    while (idx < 6 && cyc < 60) begin
      byte_in    = tv[idx];
      byte_valid = (cyc % 2 == 0);
      if (byte_valid && byte_ready) idx++;
      else if (!byte_valid && idx >= 2 && idx < 6)
        check("tg_rdy_hold", 32'(byte_ready), 32'd1);
      tick();
      cyc++;
    end
    byte_valid = 1'b0;
    check("tg_all_sent", idx,    32'd6);
    check("tg_wren",     32'(wr_en), 32'd1);
    tick();
    check("tg_nwr",  n_wr - wr0,   32'd1);
    check("tg_data", last_wr_data, 32'hDEADBEEF);
    check("tg_addr", last_wr_addr, 32'h0);
    check("tg_done", 32'(done),    32'd1);

    // ---- reset in the middle of a 3-word load
    pulse_start();
    send_byte(8'h03); send_byte(8'h00);
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
    send_byte(8'h55); send_byte(8'h66);
    check("mr_pre_data", wr_data, 32'h44332211);
    reset = 1'b1;
    #1;
    check_reset_vals("mr");
    tick();
    reset = 1'b0;
    tick();
    wr0 = n_wr;
    send_byte(8'h01); send_byte(8'h00);
    send_byte(8'h13); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
    check("mr_addr", wr_addr, 32'h0);
    check("mr_data", wr_data, 32'h00000013);
    tick();
    check("mr_done", 32'(done), 32'd1);
    check("mr_nwr",  n_wr - wr0, 32'd1);

    // ---- start ignored mid-word, then honoured in DONE
    pulse_start();
    send_byte(8'h01); send_byte(8'h00);
    send_byte(8'hA1); send_byte(8'hB2);
    pulse_start();
    check("sm_rdy",  32'(byte_ready), 32'd1);
    check("sm_hold", 32'(cpu_hold),   32'd1);
    send_byte(8'hC3); send_byte(8'hD4);
    check("sm_data", wr_data, 32'hD4C3B2A1);
    check("sm_addr", wr_addr, 32'h0);
    tick();
    check("sm_done", 32'(done), 32'd1);
    pulse_start();
    check("sm2_hold", 32'(cpu_hold),   32'd1);
    check("sm2_done", 32'(done),       32'd0);
    check("sm2_rdy",  32'(byte_ready), 32'd1);
    send_byte(8'h01); send_byte(8'h00);
    send_byte(8'h78); send_byte(8'h56); send_byte(8'h34); send_byte(8'h12);
    check("sm2_data", wr_data, 32'h12345678);
    tick();
    check("sm2_fin", 32'(done), 32'd1);

    // ---- count == DEPTH boundary: 64 words, word i = {i,i,i,i}
    pulse_start();
    wr0 = n_wr;
    send_byte(8'h40); send_byte(8'h00);
    check("full_no_err", 32'(error), 32'd0);
    for (int i = 0; i < 64; i++) begin
      for (int j = 0; j < 4; j++) send_byte(8'(i));
    end
    check("full_last_addr", wr_addr, 32'h000000FC);
    check("full_last_data", wr_data, 32'h3F3F3F3F);
    tick();
    check("full_nwr",  n_wr - wr0,   32'd64);
    check("full_done", 32'(done),    32'd1);
    check("full_hold", 32'(cpu_hold), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Boot-time program loader; the write side of the instruction memory that the single-cycle datapath reads through PC.
- Takes a byte stream (length header, then little-endian instruction words) over a valid/ready handshake and issues word writes to the instruction-memory write port.
- Holds the processor in reset until a load completes; a new load can be started after completion or after an error.

Parameters:
- DEPTH, 64, instruction memory size in 32-bit words; header count above this is an error.
- CNT_W, 16, width of the word-count header field and of the internal counters.

Ports:
- clock  input  1  system clock; all state on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  single-cycle pulse; restarts a load, honoured only in DONE or ERR.
- byte_in  input  8  stream data byte.
- byte_valid  input  1  byte_in is valid.
- byte_ready  output  1  loader accepts a byte this cycle; transfer occurs when byte_valid && byte_ready.
- wr_en  output  1  instruction-memory write strobe, one cycle per word.
- wr_addr  output  32  byte address of the word, always word-aligned (4*index).
- wr_data  output  32  instruction word.
- cpu_hold  output  1  drives the processor reset; high while not in DONE.
- done  output  1  load complete; high in DONE.
- error  output  1  header count exceeded DEPTH; high in ERR.

Behaviour:
- All outputs are registered.
- Reset values: byte_ready=0, wr_en=0, wr_addr=0, wr_data=0, cpu_hold=1, done=0, error=0. The FSM is in LEN_LO, internal counters are 0, and the byte assembly register is 0.
- byte_ready is 1 in LEN_LO, LEN_HI and DATA, and 0 otherwise. A single cycle is needed after reset deassert before the registered byte_ready rises.
- LEN_LO: on transfer, latch count[7:0] and go to LEN_HI.
- LEN_HI: on transfer, latch count[15:8], then:
  - full count = 0 -> DONE;
  - full count > DEPTH -> ERR;
  - otherwise -> DATA with byte index 0 and word index 0.
- DATA: each transfer stores the byte at lane byte_idx; byte 0 lands in bits [7:0]. byte_idx increments mod 4. On the 4th byte, go to WRITE.
- WRITE: exactly one cycle.
  - wr_en=1, wr_data={b3,b2,b1,b0}, wr_addr=4*word_idx, byte_ready=0.
  - Then word_idx increments. If word_idx+1 == count -> DONE, else -> DATA.
- Latency: 4th byte accepted at edge N -> wr_en high during cycle N+1 -> the next write can follow 4 transfers later at the earliest. Peak throughput is 4 bytes per 5 cycles.
- DONE: cpu_hold=0, done=1, wr_en=0. The processor starts at PC=0 on the cycle after cpu_hold falls.
- ERR: cpu_hold=1, error=1, byte_ready=0. Stream bytes are not consumed.
- start in DONE or ERR -> LEN_LO next cycle, with cpu_hold=1, done=0, error=0, and counters and wr_addr cleared. start in any other state is ignored.
- byte_valid low in DATA, LEN_LO or LEN_HI: the state holds and no partial-byte progress is made. Gaps of any length are legal.
- wr_en never asserts outside WRITE. wr_data and wr_addr hold their last values otherwise.
- Reset mid-load: immediate return to the reset state. Partially written memory contents are not cleared; the next load overwrites them.
- count = DEPTH is legal: the last write goes to wr_addr = 4*(DEPTH-1). No address wrap is possible.

Decomposition:
- Shared package:
  - FSM state encoding: LEN_LO, LEN_HI, DATA, WRITE, DONE, ERR (3 bits).
  - Default DEPTH constant, shared with inst_mem so both use the same size.
- Optional sub-module byte_packer: a 2-bit lane counter plus a 32-bit shift/lane register that emits a word_ready pulse. All other logic stays flat in imem_loader.

Test Plan:
- Reset then stream 0x02,0x00, 0x13,0x05,0x50,0x00, 0x93,0x05,0x70,0x00 -> two wr_en pulses: (addr 0x0, data 0x00500513) and (addr 0x4, data 0x00700593). done=1 and cpu_hold=0 the cycle after the 2nd write.
- Header 0x00,0x00 -> no wr_en; DONE reached the cycle after the 2nd byte; done=1.
- Header 0x41,0x00 (65 > DEPTH=64) -> error=1, cpu_hold=1, byte_ready=0. Pulse start -> error=0, byte_ready=1, back in LEN_LO.
- One-word load with byte_valid toggled 1/0 every cycle -> single write, data 0xDEADBEEF from bytes EF,BE,AD,DE. byte_ready holds and no byte is lost or duplicated.
- Assert reset after 6 bytes of a 3-word load -> all outputs at reset values on the same edge. Reload 1 word 0x00000013 -> write at addr 0x0, done=1.
- start pulsed in DATA mid-word -> ignored. Load completes normally with count=1, then start in DONE -> cpu_hold=1, done=0, a new load accepted.
